mix_cols_enc_seq: RTL and testbench
===================================

# mix_cols_enc_seq

Sequential AES MixColumns engine for the encryption datapath. It accepts a 128-bit state over a valid/ready handshake and applies the forward MixColumns matrix {02,03,01,01} column by column. It returns the result over a second valid/ready handshake. It sits between ShiftRows and AddRoundKey in the encrypt round, and is the forward counterpart of the column-wise inverse MixColumns used by the decrypt round.

## Interface
- COLS_PER_CYCLE, 1, columns processed per BUSY cycle; legal values 1, 2, 4; any other value is a fatal elaboration error.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid_i  input  1  state_i is valid.
- in_ready_o  output  1  engine can accept a state (IDLE only).
- state_i  input  128  input state; column c = state_i[127-32c -: 32]; within a column, byte [31:24] = row 0, byte [7:0] = row 3.
- out_valid_o  output  1  state_o holds a finished result.
- out_ready_i  input  1  downstream accepts state_o.
- state_o  output  128  result state, same packing as state_i.
- last_round_i  input  1  only present with MIX_COLS_LAST_RND_EN; sampled at input handshake.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready_o=1. On in_valid_i & in_ready_o, latch state_i into the input register, clear col_cnt, go to BUSY.
- BUSY: each cycle, compute COLS_PER_CYCLE columns starting at col_cnt and write them into the matching slices of the result register. col_cnt += COLS_PER_CYCLE. After the last column is written (col_cnt reaches 4 - COLS_PER_CYCLE), go to DONE.
- DONE: out_valid_o=1 and state_o is stable. On out_ready_i, go to IDLE. While out_ready_i=0, hold all outputs.
- Per column (a0..a3 -> b0..b3):
  - b0 = 2a0^3a1^a2^a3
  - b1 = a0^2a1^3a2^a3
  - b2 = a0^a1^2a2^3a3
  - b3 = 3a0^a1^a2^2a3
- GF arithmetic:
  - 2x = xtime(x) = {x[6:0],0} ^ (x[7] ? 8'h1b : 0)
  - 3x = xtime(x)^x
  - All values are 8-bit; no widening.
- in_valid_i is ignored outside IDLE. state_i is not required to remain stable after acceptance.
- No overlap: a new state is accepted only after the previous result's output handshake completes.

## Timing
- Reset (rst=1 at an edge) forces:
  - state to IDLE, col_cnt 0
  - out_valid_o 0, state_o 128'h0
  - in_ready_o 0 while rst is high, 1 in the first cycle after rst deasserts.
- Latency: out_valid_o rises 4/COLS_PER_CYCLE edges after the input-accepting edge (4, 2 or 1).
- Minimum block period: 4/COLS_PER_CYCLE + 2 edges (accept, BUSY, output handshake).
- Output handshake and next input handshake cannot share an edge (in_ready_o=0 in DONE).
- Reset mid-BUSY or in DONE: the block is discarded, no output is produced, and out_valid_o is 0 in the next cycle.
- out_ready_i held high before DONE has no effect; the transfer occurs on the first DONE edge.

## Configuration
- MIX_COLS_LAST_RND_EN defined:
  - last_round_i port exists and is registered at input acceptance.
  - If set, the BUSY cycles copy input columns unchanged into the result register, for AES round 10, which has no MixColumns.
  - Latency and handshake are identical to the normal path.
- Not defined: port absent; MixColumns is always applied.

## Structure
- Shared package aes_mix_pkg:
  - STATE_W=128, COL_W=32
  - GF_POLY=8'h1b
  - xtime function
  - FSM state enum {IDLE,BUSY,DONE}
- Sub-module mul_cols_enc (col_i[31:0] -> col_o[31:0]): combinational single-column forward MixColumns, instantiated COLS_PER_CYCLE times.

## Test plan
- Single column: state_i = db135345_f20a225c_01010101_c6c6c6c6 -> state_o = 8e4da1bc_9fdc589d_01010101_c6c6c6c6, out_valid_o 4 edges after accept (COLS_PER_CYCLE=1).
- FIPS-197 round 1: d4bf5d30_e0b452ae_b84111f1_1e2798e5 -> 046681e5_e0cb199a_48f8d37a_2806264c. Repeat for COLS_PER_CYCLE=2 and 4 and check latency 2 and 1.
- Backpressure: hold out_ready_i=0 for 10 cycles in DONE -> out_valid_o and state_o stable, in_ready_o=0, and a pulsed in_valid_i is ignored.
- Back-to-back: 3 states with in_valid_i and out_ready_i held high -> 3 correct results in order, 6-edge period each (COLS_PER_CYCLE=1).
- Reset mid-BUSY after 2 columns -> out_valid_o=0, state_o=0, in_ready_o=1 after release; the next input d4d4d4d5_2d26314c_... produces d5d5d7d6_4d7ebdf8_... correctly.
- MIX_COLS_LAST_RND_EN with last_round_i=1: state_i = d4bf5d30_... -> state_o equals state_i, same latency. With last_round_i=0 -> normal MixColumns result.

Source files
------------

// File: rtl/aes_mix_pkg.sv
// Shared types and GF(2^8) helpers for the AES forward MixColumns engine.
// Optional last-round bypass is enabled by defining MIX_COLS_LAST_RND_EN.
package aes_mix_pkg;

  localparam int STATE_W = 128;
  localparam int COL_W   = 32;

  localparam logic [7:0] GF_POLY = 8'h1b;

  typedef logic [COL_W-1:0] col_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mix_state_e;

  function automatic logic [7:0] xtime(
    input logic [7:0] x
  );
    return {x[6:0], 1'b0} ^ (x[7] ? GF_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/mul_cols_enc.sv
// Combinational forward MixColumns on one 32-bit column.
// Row 0 sits in col_i[31:24], row 3 in col_i[7:0].
module mul_cols_enc
  import aes_mix_pkg::*;
(
  input  logic [COL_W-1:0] col_i,
  output logic [COL_W-1:0] col_o
);

  logic [7:0] a0, a1, a2, a3;
  logic [7:0] x0, x1, x2, x3;
  logic [7:0] b0, b1, b2, b3;

  assign a0 = col_i[31:24];
  assign a1 = col_i[23:16];
  assign a2 = col_i[15:8];
  assign a3 = col_i[7:0];

  assign x0 = xtime(a0);
  assign x1 = xtime(a1);
  assign x2 = xtime(a2);
  assign x3 = xtime(a3);

  // 3a is folded in as xtime(a) ^ a
  assign b0 = x0 ^ (x1 ^ a1) ^ a2 ^ a3;
  assign b1 = a0 ^ x1 ^ (x2 ^ a2) ^ a3;
  assign b2 = a0 ^ a1 ^ x2 ^ (x3 ^ a3);
  assign b3 = (x0 ^ a0) ^ a1 ^ a2 ^ x3;

  assign col_o = {b0, b1, b2, b3};

endmodule

// File: rtl/mix_cols_enc_seq.sv
// Sequential AES forward MixColumns, COLS_PER_CYCLE columns per BUSY cycle.
// Define MIX_COLS_LAST_RND_EN to add last_round_i (round-10 bypass).
module mix_cols_enc_seq
  import aes_mix_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [STATE_W-1:0] state_i,
`ifdef MIX_COLS_LAST_RND_EN
  input  logic               last_round_i,
`endif
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [STATE_W-1:0] state_o
);

  if (COLS_PER_CYCLE != 1 &&
      COLS_PER_CYCLE != 2 &&
      COLS_PER_CYCLE != 4) begin : g_bad_cfg
    $fatal(1, "COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] CNT_LAST = 2'(4 - COLS_PER_CYCLE);

  mix_state_e         state_q, state_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [STATE_W-1:0] in_q, in_d;
  logic [STATE_W-1:0] res_q, res_d;

  col_t       res_a [COLS_PER_CYCLE];
  logic [1:0] idx_a [COLS_PER_CYCLE];

`ifdef MIX_COLS_LAST_RND_EN
  logic last_q, last_d;
`endif

  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
    col_t src, mix;

    assign idx_a[k] = cnt_q + 2'(k);
    assign src = in_q[COL_W*(3-int'(idx_a[k])) +: COL_W];

    mul_cols_enc u_mul (
      .col_i (src),
      .col_o (mix)
    );

`ifdef MIX_COLS_LAST_RND_EN
    // Round 10 skips MixColumns: pass the column through
    assign res_a[k] = last_q ? src : mix;
`else
    assign res_a[k] = mix;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      in_q    <= '0;
      res_q   <= '0;
`ifdef MIX_COLS_LAST_RND_EN
      last_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      in_q    <= in_d;
      res_q   <= res_d;
`ifdef MIX_COLS_LAST_RND_EN
      last_q  <= last_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    in_d    = in_q;
    res_d   = res_q;
`ifdef MIX_COLS_LAST_RND_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          in_d    = state_i;
          cnt_d   = 2'd0;
          state_d = BUSY;
`ifdef MIX_COLS_LAST_RND_EN
          last_d  = last_round_i;
`endif
        end
      end
      BUSY: begin
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
          res_d[COL_W*(3-int'(idx_a[k])) +: COL_W] = res_a[k];
        end
        cnt_d = cnt_q + CNT_STEP;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready_o  = (state_q == IDLE) && !rst;
  assign out_valid_o = (state_q == DONE);
  assign state_o     = res_q;

endmodule

// File: tb/tb_mix_cols_enc_seq.sv
// Bench for mix_cols_enc_seq: three instances (1, 2, 4 columns/cycle)
// checked against a GF(2^8) matrix-multiply reference model.
module tb_mix_cols_enc_seq;

  logic         clk;
  logic         rst;
  logic [2:0]   in_v;
  logic [2:0]   in_rdy;
  logic [2:0]   out_v;
  logic [2:0]   out_r;
  logic [127:0] st_in  [3];
  logic [127:0] st_out [3];
`ifdef MIX_COLS_LAST_RND_EN
  logic [2:0]   lr;
`endif

  int pass_cnt;
  int total_cnt;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int CPC = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    mix_cols_enc_seq #(.COLS_PER_CYCLE(CPC)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid_i   (in_v[g]),
      .in_ready_o   (in_rdy[g]),
      .state_i      (st_in[g]),
`ifdef MIX_COLS_LAST_RND_EN
      .last_round_i (lr[g]),
`endif
      .out_valid_o  (out_v[g]),
      .out_ready_i  (out_r[g]),
      .state_o      (st_out[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // GF(2^8) multiply by shift-and-add over the AES polynomial
  function automatic logic [7:0] gmul(input int a, input int b);
    int p;
    int x;
    p = 0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (((b >> i) & 1) != 0) p = p ^ x;
      x = x << 1;
      if ((x & 'h100) != 0) x = x ^ 'h11b;
    end
    return p[7:0];
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] s);
    int coef [4];
    logic [127:0] r;
    logic [7:0] acc;
    coef = '{2, 3, 1, 1};
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) begin
          acc = acc ^ gmul(coef[(k - row + 4) % 4],
                           int'(s[127-32*c-8*k -: 8]));
        end
        r[127-32*c-8*row -: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_xact(input int d, input logic [127:0] din,
                         output int lat, output logic [127:0] dout,
                         output logic post_v, output logic post_rdy);
    int n;
    in_v[d]  = 1'b1;
    st_in[d] = din;
    tick();
    in_v[d]  = 1'b0;
    st_in[d] = ~din;
    n = 0;
    while (!out_v[d] && n < 20) begin
      tick();
      n++;
    end
    lat  = out_v[d] ? n : -1;
    dout = st_out[d];
    out_r[d] = 1'b1;
    tick();
    out_r[d] = 1'b0;
    post_v   = out_v[d];
    post_rdy = in_rdy[d];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    for (int d = 0; d < 3; d++) begin
      total_cnt++;
      if (out_v[d] !== 1'b0 || st_out[d] !== 128'h0 || in_rdy[d] !== 1'b0) begin
        $display("FAIL reset[%0d]: v=%b rdy=%b out=%h, want v=0 rdy=0 out=0",
                 d, out_v[d], in_rdy[d], st_out[d]);
      end else pass_cnt++;
    end
    rst = 1'b0;
    #1;
    total_cnt++;
    if (in_rdy !== 3'b111 || out_v !== 3'b000) begin
      $display("FAIL reset_release: rdy=%b v=%b, want 111/000", in_rdy, out_v);
    end else pass_cnt++;
  endtask

  task automatic test_single();
    int lat;
    logic [127:0] o;
    logic pv, pr;
    do_xact(0, 128'hdb135345_f20a225c_01010101_c6c6c6c6, lat, o, pv, pr);
    total_cnt++;
    if (o !== 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6) begin
      $display("FAIL single_col: got %h want %h", o,
               128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);
    end else pass_cnt++;
    total_cnt++;
    if (lat !== 4 || pv !== 1'b0 || pr !== 1'b1) begin
      $display("FAIL single_lat: lat=%0d v=%b rdy=%b, want 4/0/1", lat, pv, pr);
    end else pass_cnt++;
  endtask

  task automatic test_fips();
    int lat;
    logic [127:0] o;
    logic pv, pr;
    int want_lat [3];
    want_lat = '{4, 2, 1};
    for (int d = 0; d < 3; d++) begin
      do_xact(d, 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, lat, o, pv, pr);
      total_cnt++;
      if (o !== 128'h046681e5_e0cb199a_48f8d37a_2806264c ||
          lat !== want_lat[d]) begin
        $display("FAIL fips[%0d]: got %h lat %0d want %h lat %0d", d, o, lat,
                 128'h046681e5_e0cb199a_48f8d37a_2806264c, want_lat[d]);
      end else pass_cnt++;
    end
  endtask

  task automatic test_random();
    int lat;
    logic [127:0] din, o, exp;
    logic pv, pr;
    int want_lat [3];
    want_lat = '{4, 2, 1};
    for (int i = 0; i < 24; i++) begin
      din = rnd128();
      exp = ref_mix(din);
      do_xact(i % 3, din, lat, o, pv, pr);
      total_cnt++;
      if (o !== exp || lat !== want_lat[i % 3] || pv !== 1'b0) begin
        $display("FAIL random[%0d] dut%0d: got %h lat %0d want %h lat %0d",
                 i, i % 3, o, lat, exp, want_lat[i % 3]);
      end else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] din, exp;
    int n;
    din = rnd128();
    exp = ref_mix(din);
    in_v[0]  = 1'b1;
    st_in[0] = din;
    tick();
    in_v[0] = 1'b0;
    n = 0;
    while (!out_v[0] && n < 20) begin
      tick();
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      total_cnt++;
      if (out_v[0] !== 1'b1 || st_out[0] !== exp || in_rdy[0] !== 1'b0) begin
        $display("FAIL hold[%0d]: v=%b rdy=%b out=%h want v=1 rdy=0 out=%h",
                 i, out_v[0], in_rdy[0], st_out[0], exp);
      end else pass_cnt++;
      in_v[0]  = (i == 3);
      st_in[0] = rnd128();
      tick();
    end
    in_v[0]  = 1'b0;
    out_r[0] = 1'b1;
    tick();
    out_r[0] = 1'b0;
    total_cnt++;
    if (out_v[0] !== 1'b0 || in_rdy[0] !== 1'b1) begin
      $display("FAIL hold_release: v=%b rdy=%b, want 0/1", out_v[0], in_rdy[0]);
    end else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [127:0] din [3];
    logic [127:0] exp [$];
    logic [127:0] obs;
    int acc_t [3];
    int ai, ri, cyc;
    logic acc, hs;
    for (int i = 0; i < 3; i++) begin
      din[i] = rnd128();
      exp.push_back(ref_mix(din[i]));
      acc_t[i] = 0;
    end
    ai = 0;
    ri = 0;
    cyc = 0;
    in_v[0]  = 1'b1;
    st_in[0] = din[0];
    out_r[0] = 1'b1;
    while (ri < 3 && cyc < 80) begin
      acc = in_v[0] & in_rdy[0];
      hs  = out_v[0] & out_r[0];
      obs = st_out[0];
      tick();
      cyc++;
      if (acc) begin
        acc_t[ai] = cyc;
        ai++;
        if (ai < 3) st_in[0] = din[ai];
        else in_v[0] = 1'b0;
      end
      if (hs) begin
        total_cnt++;
        if (obs !== exp[0]) begin
          $display("FAIL b2b_data[%0d]: got %h want %h", ri, obs, exp[0]);
        end else pass_cnt++;
        void'(exp.pop_front());
        ri++;
      end
    end
    in_v[0]  = 1'b0;
    out_r[0] = 1'b0;
    total_cnt++;
    if (ri != 3 || ai != 3) begin
      $display("FAIL b2b_count: results %0d accepts %0d, want 3/3", ri, ai);
    end else pass_cnt++;
    total_cnt++;
    if (acc_t[1] - acc_t[0] != 6 || acc_t[2] - acc_t[1] != 6) begin
      $display("FAIL b2b_period: %0d,%0d want 6,6",
               acc_t[1] - acc_t[0], acc_t[2] - acc_t[1]);
    end else pass_cnt++;
  endtask

  task automatic test_reset_busy();
    int lat;
    logic [127:0] o;
    logic pv, pr;
    in_v[0]  = 1'b1;
    st_in[0] = rnd128();
    tick();
    in_v[0] = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    total_cnt++;
    if (out_v[0] !== 1'b0 || st_out[0] !== 128'h0 || in_rdy[0] !== 1'b1) begin
      $display("FAIL rst_busy: v=%b rdy=%b out=%h, want 0/1/0",
               out_v[0], in_rdy[0], st_out[0]);
    end else pass_cnt++;
    tick();
    total_cnt++;
    if (out_v[0] !== 1'b0) begin
      $display("FAIL rst_busy_stale: v=%b want 0", out_v[0]);
    end else pass_cnt++;
    do_xact(0, 128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6, lat, o, pv, pr);
    total_cnt++;
    if (o !== 128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6 || lat !== 4) begin
      $display("FAIL rst_next: got %h lat %0d want %h lat 4", o, lat,
               128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6);
    end else pass_cnt++;
  endtask

`ifdef MIX_COLS_LAST_RND_EN
  task automatic test_last_round();
    int lat;
    logic [127:0] o;
    logic pv, pr;
    logic [127:0] din;
    din = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    lr[0] = 1'b1;
    do_xact(0, din, lat, o, pv, pr);
    lr[0] = 1'b0;
    total_cnt++;
    if (o !== din || lat !== 4) begin
      $display("FAIL last_rnd: got %h lat %0d want %h lat 4", o, lat, din);
    end else pass_cnt++;
    do_xact(0, din, lat, o, pv, pr);
    total_cnt++;
    if (o !== ref_mix(din) || lat !== 4) begin
      $display("FAIL last_rnd_off: got %h lat %0d want %h", o, lat, ref_mix(din));
    end else pass_cnt++;
  endtask
`endif

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst   = 1'b1;
    in_v  = 3'b000;
    out_r = 3'b000;
`ifdef MIX_COLS_LAST_RND_EN
    lr    = 3'b000;
`endif
    for (int d = 0; d < 3; d++) st_in[d] = '0;
    test_reset();
    test_single();
    test_fips();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_busy();
`ifdef MIX_COLS_LAST_RND_EN
    test_last_round();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
